demux_stream_1ton: RTL and testbench
====================================

# demux_stream_1ton

Registered 1-to-N stream demultiplexer with valid/ready handshake, the parametrised successor of the combinational 1-to-2 demux. One input stream is steered to one of N output channels, either by an explicit select or by an internal round-robin pointer. Each channel has a one-entry output register, so a stalled channel does not block traffic to the others. Out-of-range selects are dropped and counted. The block sits between a single producer and N independent consumers.

## Interface
- WIDTH, 8, data width in bits (≥1)
- N, 4, number of output channels (2..16)
- SEL_W, $clog2(N), select width (derived; not overridden)
- clk  input  1  sole clock, rising edge
- rst_n  input  1  reset, asynchronous assert, active-low
- mode  input  1  0 = select mode (use in_sel), 1 = round-robin mode (ignore in_sel)
- in_valid  input  1  input word present
- in_data  input  WIDTH  input word
- in_sel  input  SEL_W  destination channel in select mode
- in_ready  output  1  input word accepted this cycle when high with in_valid
- out_valid  output  N  per-channel word present
- out_data  output  N*WIDTH  channel k data on bits [k*WIDTH +: WIDTH]
- out_ready  input  N  per-channel consumer ready
- rr_ptr  output  SEL_W  current round-robin destination
- drop_cnt  output  8  saturating count of dropped words

## Operation
- Destination: dest = (mode ? rr_ptr : in_sel).
- Channel k register is "free" when !out_valid[k] or out_ready[k] (drain and refill in the same cycle are allowed).
- in_ready = (dest ≥ N) ? 1 : free[dest]. Purely combinational from the registered state, mode, in_sel and out_ready. No dependency on in_valid.
- Accept when in_valid && in_ready:
  - If dest < N: out_data[dest] ← in_data and out_valid[dest] ← 1.
  - If dest ≥ N (select mode only, possible when N is not a power of two): the word is discarded and drop_cnt increments, saturating at 255.
- Drain: when out_valid[k] && out_ready[k] and there is no refill of k, out_valid[k] ← 0. out_data[k] holds its last value.
- Round-robin pointer: advances only on an accept in mode 1, wrapping from N-1 to 0. Mode 0 never changes rr_ptr.
- Mode changes take effect on the next cycle's dest calculation. There is no flush. Words already held in channel registers are unaffected.
- Channels are independent; any subset of out_valid may be high at the same time.
- Per-channel order is preserved. There is no ordering guarantee across channels.

## Timing
- Reset values (async on rst_n low): out_valid = 0, out_data = 0, rr_ptr = 0, drop_cnt = 0. in_ready then follows the combinational rule.
- Latency: 1 cycle. A word accepted at edge t shows as out_valid[dest] high after edge t.
- Throughput: 1 word per cycle into any channel whose consumer holds out_ready high. Back-to-back writes to the same channel are allowed.
- Full channel (out_valid[k]=1 and out_ready[k]=0) with dest = k: in_ready = 0. The producer must hold in_valid and in_data stable until acceptance. In mode 1 rr_ptr stalls, and the block does not skip to a free channel.
- Simultaneous drain and refill of channel k: out_valid[k] stays 1 and out_data[k] takes the new word.
- Reset mid-transfer: all held words are lost; outputs return to reset values immediately, without waiting for a clock edge.
- drop_cnt at 255 stays at 255. Drops are still accepted (in_ready = 1).

## Structure
- No shared-package contents beyond a helper for the SEL_W clog2. Any mode encoding constant (MODE_SEL=0, MODE_RR=1) goes in the project's common package.
- One sub-module is natural: demux_chan_reg, a one-entry valid/data register with load/drain. It is instantiated N times in a generate loop.
- The top level holds dest decode, in_ready mux, rr_ptr and drop_cnt.

## Test plan
- Reset: hold rst_n=0 with random inputs → out_valid=0, rr_ptr=0, drop_cnt=0. Release and keep all out_ready=1. Send in_data=8'hA5, in_sel=2, mode=0 → next cycle out_valid=4'b0100 and out_data[2]=8'hA5.
- Backpressure: N=4, out_ready[1]=0. Send two words to channel 1 → first accepted. Second sees in_ready=0 and is held until out_ready[1]=1, then appears one cycle later. Data order 8'h11, 8'h22 is preserved.
- Round-robin: mode=1, all out_ready=1, 6 back-to-back words 0..5 → channels receive 0,1,2,3,0,1 and rr_ptr=2 afterwards. Then stall channel 2 → rr_ptr stays 2 and in_ready=0.
- Drop: N=3, mode=0, in_sel=3, 300 words → in_ready=1 throughout, no out_valid rises, drop_cnt saturates at 255.
- Drain/refill: channel 0 full with out_ready[0]=1 and a new word 8'h5A arriving the same cycle → out_valid[0] stays 1 and out_data[0]=8'h5A.
- Async reset mid-stream: assert rst_n between clock edges with 3 channels full → out_valid=0 immediately (before the next edge) and rr_ptr=0.

Source files
------------

// File: rtl/demux_stream_1ton_pkg.sv
// Shared constants and helpers for the 1-to-N stream demultiplexer.
package demux_stream_1ton_pkg;

  localparam logic MODE_SEL = 1'b0;
  localparam logic MODE_RR  = 1'b1;

  // Select width for N channels; never narrower than one bit.
  function automatic int sel_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/demux_chan_reg.sv
// One-entry valid/data output register; load wins over drain so a word
// can be consumed and replaced in the same cycle.
module demux_chan_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             ready_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic             free_o
);

  logic             valid_q;
  logic [WIDTH-1:0] data_q;

  assign free_o  = !valid_q || ready_i;
  assign valid_o = valid_q;
  assign data_o  = data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      data_q  <= data_i;
    end else if (ready_i) begin
      valid_q <= 1'b0;
    end
  end

endmodule

// File: rtl/demux_stream_1ton.sv
// Registered 1-to-N stream demux: explicit select or round-robin steering,
// per-channel one-entry registers, out-of-range selects dropped and counted.
module demux_stream_1ton
  import demux_stream_1ton_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int N     = 4,
  parameter int SEL_W = sel_width(N)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               mode,
  input  logic               in_valid,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SEL_W-1:0]   in_sel,
  output logic               in_ready,
  output logic [N-1:0]       out_valid,
  output logic [N*WIDTH-1:0] out_data,
  input  logic [N-1:0]       out_ready,
  output logic [SEL_W-1:0]   rr_ptr,
  output logic [7:0]         drop_cnt
);

  localparam int SLOTS = 1 << SEL_W;

  logic [SEL_W-1:0] dest;
  logic             dest_ok;
  logic             accept;
  logic [N-1:0]     free;
  logic [N-1:0]     load;
  logic [SLOTS-1:0] free_ext;
  logic [SEL_W-1:0] rr_q, rr_d;
  logic [7:0]       drop_q, drop_d;

  assign dest    = (mode == MODE_RR) ? rr_q : in_sel;
  assign dest_ok = ({1'b0, dest} < (SEL_W + 1)'(N));

  // Unused select codes read as always-ready so drops never stall the producer.
  always_comb begin
    free_ext        = '1;
    free_ext[N-1:0] = free;
  end

  assign in_ready = free_ext[dest];
  assign accept   = in_valid && in_ready;

  for (genvar k = 0; k < N; k++) begin : g_chan
    assign load[k] = accept && dest_ok && (dest == SEL_W'(k));

    demux_chan_reg #(
      .WIDTH(WIDTH)
    ) u_chan (
      .clk    (clk),
      .rst_n  (rst_n),
      .load_i (load[k]),
      .data_i (in_data),
      .ready_i(out_ready[k]),
      .valid_o(out_valid[k]),
      .data_o (out_data[k*WIDTH +: WIDTH]),
      .free_o (free[k])
    );
  end

  always_comb begin
    rr_d   = rr_q;
    drop_d = drop_q;
    if (accept && (mode == MODE_RR)) begin
      rr_d = (rr_q == SEL_W'(N - 1)) ? '0 : rr_q + SEL_W'(1);
    end
    if (accept && !dest_ok && (drop_q != 8'hFF)) begin
      drop_d = drop_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q   <= '0;
      drop_q <= '0;
    end else begin
      rr_q   <= rr_d;
      drop_q <= drop_d;
    end
  end

  assign rr_ptr   = rr_q;
  assign drop_cnt = drop_q;

endmodule

// File: tb/tb_demux_stream_1ton.sv
// Bench for demux_stream_1ton: a 4-channel and a 3-channel instance share stimulus.
module tb_demux_stream_1ton;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mode, in_valid;
  logic [7:0]  in_data;
  logic [1:0]  in_sel;
  logic [3:0]  out_ready;

  logic        ir4, ir3;
  logic [3:0]  ov4;
  logic [31:0] od4;
  logic [1:0]  rr4;
  logic [7:0]  dc4;
  logic [2:0]  ov3;
  logic [23:0] od3;
  logic [1:0]  rr3;
  logic [7:0]  dc3;

  int tests = 0;
  int fails = 0;
  logic last_ir4, last_ir3;

  always #5 clk = ~clk;

  demux_stream_1ton #(.WIDTH(8), .N(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .mode(mode), .in_valid(in_valid), .in_data(in_data),
    .in_sel(in_sel), .in_ready(ir4), .out_valid(ov4), .out_data(od4),
    .out_ready(out_ready), .rr_ptr(rr4), .drop_cnt(dc4)
  );

  demux_stream_1ton #(.WIDTH(8), .N(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .mode(mode), .in_valid(in_valid), .in_data(in_data),
    .in_sel(in_sel), .in_ready(ir3), .out_valid(ov3), .out_data(od3),
    .out_ready(out_ready[2:0]), .rr_ptr(rr3), .drop_cnt(dc3)
  );

  // Reference model: per instance, which channels hold a word and what it is.
  int         nch[2] = '{4, 3};
  bit         mv[2][4];
  logic [7:0] md[2][4];
  int         mrr[2];
  int         mdrop[2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int m_dest(input int d);
    return mode ? mrr[d] : int'(in_sel);
  endfunction

  function automatic bit m_ready(input int d);
    int dst = m_dest(d);
    if (dst >= nch[d]) return 1'b1;
    return !mv[d][dst] || out_ready[dst];
  endfunction

  task automatic m_reset();
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < 4; k++) begin
        mv[d][k] = 1'b0;
        md[d][k] = 8'h00;
      end
      mrr[d]   = 0;
      mdrop[d] = 0;
    end
  endtask

  task automatic m_step();
    for (int d = 0; d < 2; d++) begin
      int dst = m_dest(d);
      bit rdy = m_ready(d);
      for (int k = 0; k < nch[d]; k++)
        if (mv[d][k] && out_ready[k]) mv[d][k] = 1'b0;
      if (in_valid && rdy) begin
        if (dst < nch[d]) begin
          mv[d][dst] = 1'b1;
          md[d][dst] = in_data;
        end else if (mdrop[d] < 255) begin
          mdrop[d]++;
        end
        if (mode) mrr[d] = (mrr[d] + 1) % nch[d];
      end
    end
  endtask

  task automatic check_outputs();
    logic [31:0] e_ov [2];
    logic [31:0] e_od [2];
    for (int d = 0; d < 2; d++) begin
      e_ov[d] = '0;
      e_od[d] = '0;
      for (int k = 0; k < nch[d]; k++) begin
        e_ov[d][k]       = mv[d][k];
        e_od[d][k*8 +: 8] = md[d][k];
      end
    end
    chk("out_valid4", 32'(ov4), e_ov[0]);
    chk("out_data4",  od4,      e_od[0]);
    chk("rr_ptr4",    32'(rr4), 32'(mrr[0]));
    chk("drop_cnt4",  32'(dc4), 32'(mdrop[0]));
    chk("out_valid3", 32'(ov3), e_ov[1]);
    chk("out_data3",  32'(od3), e_od[1]);
    chk("rr_ptr3",    32'(rr3), 32'(mrr[1]));
    chk("drop_cnt3",  32'(dc3), 32'(mdrop[1]));
  endtask

  // Entered one time unit after a rising edge; leaves at the same phase.
  task automatic cycle(input logic m, input logic v, input logic [7:0] dat,
                       input logic [1:0] sel, input logic [3:0] rdy);
    mode = m; in_valid = v; in_data = dat; in_sel = sel; out_ready = rdy;
    #1;
    chk("in_ready4", 32'(ir4), 32'(m_ready(0)));
    chk("in_ready3", 32'(ir3), 32'(m_ready(1)));
    last_ir4 = ir4;
    last_ir3 = ir3;
    @(posedge clk);
    m_step();
    #1;
    check_outputs();
  endtask

  initial begin
    // Reset with random inputs toggling
    rst_n = 1'b0;
    m_reset();
    for (int i = 0; i < 4; i++) begin
      mode = 1'($urandom); in_valid = 1'($urandom); in_data = 8'($urandom);
      in_sel = 2'($urandom); out_ready = 4'($urandom);
      @(posedge clk);
    end
    #1;
    check_outputs();
    rst_n = 1'b1;

    // First word to channel 2
    cycle(1'b0, 1'b1, 8'hA5, 2'd2, 4'hF);
    chk("first_valid", 32'(ov4), 32'h4);
    chk("first_data",  32'(od4[23:16]), 32'hA5);

    // Backpressure on channel 1
    cycle(1'b0, 1'b1, 8'h11, 2'd1, 4'b1101);
    chk("bp_first_acc", 32'(last_ir4), 32'd1);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b1, 8'h22, 2'd1, 4'b1101);
      chk("bp_stall", 32'(last_ir4), 32'd0);
      chk("bp_hold",  32'(od4[15:8]), 32'h11);
    end
    cycle(1'b0, 1'b1, 8'h22, 2'd1, 4'b1111);
    chk("bp_release", 32'(last_ir4), 32'd1);
    chk("bp_second",  32'(od4[15:8]), 32'h22);
    cycle(1'b0, 1'b0, 8'h00, 2'd0, 4'b1111);

    // Round-robin: six words back to back
    for (int i = 0; i < 6; i++) begin
      cycle(1'b1, 1'b1, 8'(i), 2'd0, 4'hF);
      chk("rr_chan", 32'(od4[((i % 4) * 8) +: 8]), 32'(i));
    end
    chk("rr_after6", 32'(rr4), 32'd2);
    // Fill channel 2 and stall it, then try to round-robin into it
    cycle(1'b0, 1'b1, 8'h77, 2'd2, 4'b1011);
    for (int i = 0; i < 2; i++) begin
      cycle(1'b1, 1'b1, 8'h88, 2'd0, 4'b1011);
      chk("rr_stall_rdy", 32'(last_ir4), 32'd0);
      chk("rr_stall_ptr", 32'(rr4), 32'd2);
    end
    cycle(1'b1, 1'b1, 8'h88, 2'd0, 4'b1111);
    chk("rr_resume", 32'(rr4), 32'd3);

    // Drain and refill channel 0 in one cycle
    cycle(1'b0, 1'b1, 8'h33, 2'd0, 4'hF);
    cycle(1'b0, 1'b1, 8'h5A, 2'd0, 4'hF);
    chk("refill_valid", 32'(ov4[0]), 32'd1);
    chk("refill_data",  32'(od4[7:0]), 32'h5A);

    // Out-of-range select on the 3-channel instance: all dropped
    for (int i = 0; i < 300; i++) begin
      cycle(1'b0, 1'b1, 8'($urandom), 2'd3, 4'hF);
      chk("drop_rdy", 32'(last_ir3), 32'd1);
      chk("drop_noval", 32'(ov3), 32'd0);
    end
    chk("drop_sat", 32'(dc3), 32'd255);

    // Three channels full, then asynchronous reset between edges
    cycle(1'b0, 1'b1, 8'hC0, 2'd0, 4'h0);
    cycle(1'b0, 1'b1, 8'hC1, 2'd1, 4'h0);
    cycle(1'b0, 1'b1, 8'hC2, 2'd2, 4'h0);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("areset_valid4", 32'(ov4), 32'd0);
    chk("areset_valid3", 32'(ov3), 32'd0);
    chk("areset_rr4",    32'(rr4), 32'd0);
    chk("areset_drop3",  32'(dc3), 32'd0);
    m_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom), 1'($urandom_range(0, 3) != 0), 8'($urandom),
            2'($urandom), 4'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
